// File: rtl/lcd_write_ctrl.sv
// Character-LCD write engine: serialises a byte (or a single high nibble) onto
// the LCD 4-bit bus with setup, enable pulse, inter-nibble gap and settle wait.
// All delays are cycle counts so they can be shrunk for simulation.
module lcd_write_ctrl #(
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned E_PULSE_CYC    = 12,
    parameter int unsigned NIBBLE_GAP_CYC = 50,
    parameter int unsigned CMD_GAP_CYC    = 2000,
    parameter int unsigned CLEAR_GAP_CYC  = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iNibbleOnly,
    input  logic       iValid,
    output logic       oReady,
    output logic       oDone,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_D
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counter holds 0 .. dwell-1, so it only needs to reach the largest dwell minus one.
    localparam int unsigned MaxCyc = max2(max2(max2(SETUP_CYC, E_PULSE_CYC),
                                               max2(NIBBLE_GAP_CYC, CMD_GAP_CYC)),
                                          CLEAR_GAP_CYC);
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t SetupLast = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t PulseLast = cnt_t'(E_PULSE_CYC - 1);
    localparam cnt_t GapLast   = cnt_t'(NIBBLE_GAP_CYC - 1);
    localparam cnt_t CmdLast   = cnt_t'(CMD_GAP_CYC - 1);
    localparam cnt_t ClearLast = cnt_t'(CLEAR_GAP_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StHiSetup,
        StHiPulse,
        StHiGap,
        StLoSetup,
        StLoPulse,
        StWait
    } state_e;

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       rs_q, rs_d;
    logic       nib_q, nib_d;
    logic       ready_q, ready_d;
    logic       done_q, done_d;
    logic       e_q, e_d;
    logic       lcd_rs_q, lcd_rs_d;
    logic [3:0] d_q, d_d;

    cnt_t       dwell_last;
    logic       is_clear;
    logic       last;

    // Clear Display / Return Home need the long settle wait; nibble-only writes never do.
    assign is_clear = !nib_q && !rs_q &&
                      ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));

    // Next state, dwell counter and registered LCD bus values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        rs_d       = rs_q;
        nib_d      = nib_q;
        done_d     = 1'b0;
        e_d        = 1'b0;
        d_d        = d_q;
        lcd_rs_d   = lcd_rs_q;
        dwell_last = SetupLast;

        case (state_q)
            StHiPulse, StLoPulse: dwell_last = PulseLast;
            StHiGap:              dwell_last = GapLast;
            StWait:               dwell_last = is_clear ? ClearLast : CmdLast;
            default:              dwell_last = SetupLast;
        endcase
        last = (cnt_q == dwell_last);

        case (state_q)
            StIdle: begin
                if (iValid) begin
                    state_d = StHiSetup;
                    data_d  = iData;
                    rs_d    = iRS;
                    nib_d   = iNibbleOnly;
                end
            end
            StHiSetup: if (last) state_d = StHiPulse;
            StHiPulse: if (last) state_d = nib_q ? StWait : StHiGap;
            StHiGap:   if (last) state_d = StLoSetup;
            StLoSetup: if (last) state_d = StLoPulse;
            StLoPulse: if (last) state_d = StWait;
            StWait: begin
                if (last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Every state counts its dwell from zero; idle keeps the counter parked.
        if ((state_d != state_q) || (state_q == StIdle)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + cnt_t'(1);
        end

        ready_d = (state_d == StIdle);

        // Bus values follow the state being entered so they are registered, not decoded.
        case (state_d)
            StIdle: begin
                d_d      = 4'h0;
                lcd_rs_d = 1'b0;
            end
            StHiSetup: begin
                d_d      = data_d[7:4];
                lcd_rs_d = rs_d;
            end
            StHiPulse, StLoPulse: e_d = 1'b1;
            StLoSetup: d_d = data_d[3:0];
            default: ;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            data_q   <= 8'h00;
            rs_q     <= 1'b0;
            nib_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            e_q      <= 1'b0;
            lcd_rs_q <= 1'b0;
            d_q      <= 4'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            nib_q    <= nib_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            e_q      <= e_d;
            lcd_rs_q <= lcd_rs_d;
            d_q      <= d_d;
        end
    end

    assign oReady  = ready_q;
    assign oDone   = done_q;
    assign oLCD_E  = e_q;
    assign oLCD_RS = lcd_rs_q;
    assign oLCD_RW = 1'b0;
    assign oLCD_D  = d_q;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Directed bench for lcd_write_ctrl with shrunk delays
// (SETUP=2, E_PULSE=3, NIBBLE_GAP=4, CMD_GAP=5, CLEAR_GAP=9).
module tb_lcd_write_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] iData;
    logic       iRS;
    logic       iNibbleOnly;
    logic       iValid;
    logic       oReady;
    logic       oDone;
    logic       oLCD_E;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic [3:0] oLCD_D;

    int n_checks = 0;
    int n_errors = 0;

    lcd_write_ctrl #(
        .SETUP_CYC     (2),
        .E_PULSE_CYC   (3),
        .NIBBLE_GAP_CYC(4),
        .CMD_GAP_CYC   (5),
        .CLEAR_GAP_CYC (9)
    ) dut (
        .Clock      (clk),
        .Reset      (rst),
        .iData      (iData),
        .iRS        (iRS),
        .iNibbleOnly(iNibbleOnly),
        .iValid     (iValid),
        .oReady     (oReady),
        .oDone      (oDone),
        .oLCD_E     (oLCD_E),
        .oLCD_RS    (oLCD_RS),
        .oLCD_RW    (oLCD_RW),
        .oLCD_D     (oLCD_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction: accept edge ends cycle 0, cycle k is sampled after the k-th edge.
    task automatic xfer(input string tag, input logic [7:0] data, input logic rs,
                        input logic nib, input int busy, input logic [31:0] e_mask_exp,
                        input logic [3:0] d_hi_exp, input logic [3:0] d_lo_exp);
        logic [31:0] e_mask;
        logic [31:0] busy_mask;
        logic [31:0] done_mask;
        logic [31:0] busy_exp;
        logic [3:0]  d_hi;
        logic [3:0]  d_lo;
        int          rs_bad;
        e_mask    = '0;
        busy_mask = '0;
        done_mask = '0;
        d_hi      = 4'h0;
        d_lo      = 4'h0;
        rs_bad    = 0;
        busy_exp  = ((32'd1 << (busy + 1)) - 32'd1) & ~32'd1;
        @(negedge clk);
        iData       = data;
        iRS         = rs;
        iNibbleOnly = nib;
        iValid      = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= busy + 1; k++) begin
            @(negedge clk);
            iValid = 1'b0;
            if (oLCD_E)  e_mask[k]    = 1'b1;
            if (!oReady) busy_mask[k] = 1'b1;
            if (oDone)   done_mask[k] = 1'b1;
            if ((k <= busy) && (oLCD_RS !== rs)) rs_bad++;
            if (k == 3)  d_hi = oLCD_D;
            if (k == 12) d_lo = oLCD_D;
            if (k == busy + 1) begin
                check_eq({tag, " end_ready"}, {31'd0, oReady}, 32'd1);
                check_eq({tag, " end_d"}, {28'd0, oLCD_D}, 32'd0);
                check_eq({tag, " end_rs"}, {31'd0, oLCD_RS}, 32'd0);
            end
        end
        check_eq({tag, " e_mask"}, e_mask, e_mask_exp);
        check_eq({tag, " busy_mask"}, busy_mask, busy_exp);
        check_eq({tag, " done_mask"}, done_mask, 32'd1 << (busy + 1));
        check_eq({tag, " rs_held"}, rs_bad, 32'd0);
        check_eq({tag, " d_hi"}, {28'd0, d_hi}, {28'd0, d_hi_exp});
        check_eq({tag, " d_lo"}, {28'd0, d_lo}, {28'd0, d_lo_exp});
    endtask

    initial begin
        int done_cnt;
        rst         = 1'b1;
        iData       = 8'h00;
        iRS         = 1'b0;
        iNibbleOnly = 1'b0;
        iValid      = 1'b0;

        // Reset held for two cycles.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("rst ready", {31'd0, oReady}, 32'd1);
            check_eq("rst done", {31'd0, oDone}, 32'd0);
            check_eq("rst e", {31'd0, oLCD_E}, 32'd0);
            check_eq("rst d", {28'd0, oLCD_D}, 32'd0);
            check_eq("rst rw", {31'd0, oLCD_RW}, 32'd0);
        end
        rst = 1'b0;

        // Full data byte: E at 3-5 and 12-14, 19 busy cycles.
        xfer("data48", 8'h48, 1'b1, 1'b0, 19, 32'h0000_7038, 4'h4, 4'h8);
        // Clear Display uses the long wait.
        xfer("clear01", 8'h01, 1'b0, 1'b0, 23, 32'h0000_7038, 4'h0, 4'h1);
        // Return Home also uses the long wait.
        xfer("home02", 8'h02, 1'b0, 1'b0, 23, 32'h0000_7038, 4'h0, 4'h2);
        // 0x03 as data is not a command: normal wait.
        xfer("data03", 8'h03, 1'b1, 1'b0, 19, 32'h0000_7038, 4'h0, 4'h3);
        // 0x04 as instruction: normal wait.
        xfer("cmd04", 8'h04, 1'b0, 1'b0, 19, 32'h0000_7038, 4'h0, 4'h4);
        // Nibble-only init write: one pulse, busy 10.
        xfer("nib30", 8'h30, 1'b0, 1'b1, 10, 32'h0000_0038, 4'h3, 4'h0);
        // Nibble-only 0x01 with RS=0 still uses the short wait.
        xfer("nib01", 8'h01, 1'b0, 1'b1, 10, 32'h0000_0038, 4'h0, 4'h0);

        // Back-to-back with a request ignored mid-transfer.
        @(negedge clk);
        iData       = 8'h41;
        iRS         = 1'b1;
        iNibbleOnly = 1'b0;
        iValid      = 1'b1;
        @(posedge clk);
        done_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (oDone) done_cnt++;
            if (k == 12) check_eq("b2b lo1", {28'd0, oLCD_D}, 32'h1);
            if (k == 20) begin
                check_eq("b2b done1", {31'd0, oDone}, 32'd1);
                check_eq("b2b ready1", {31'd0, oReady}, 32'd1);
            end
            if (k == 21) check_eq("b2b accept2", {31'd0, oReady}, 32'd0);
            if (k == 23) check_eq("b2b hi2", {28'd0, oLCD_D}, 32'h4);
            if (k == 32) check_eq("b2b lo2", {28'd0, oLCD_D}, 32'h2);
            if (k == 40) check_eq("b2b done2", {31'd0, oDone}, 32'd1);
            if (k == 42) check_eq("b2b idle", {31'd0, oReady}, 32'd1);
            if (k == 1)  iData = 8'h42;
            if (k == 21) iValid = 1'b0;
            if (k == 25) begin
                iValid = 1'b1;
                iData  = 8'h55;
            end
            if (k == 26) iValid = 1'b0;
        end
        check_eq("b2b done_count", done_cnt, 32'd2);

        // Reset during the high-nibble pulse.
        @(negedge clk);
        iData  = 8'h48;
        iRS    = 1'b1;
        iValid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            iValid = 1'b0;
        end
        check_eq("midrst e_before", {31'd0, oLCD_E}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst e_after", {31'd0, oLCD_E}, 32'd0);
        check_eq("midrst ready", {31'd0, oReady}, 32'd1);
        check_eq("midrst done", {31'd0, oDone}, 32'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (oDone) done_cnt++;
        end
        check_eq("midrst no_done", done_cnt, 32'd0);
        xfer("post_rst", 8'h48, 1'b1, 1'b0, 19, 32'h0000_7038, 4'h4, 4'h8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_write_ctrl.md
Name: lcd_write_ctrl

Overview:
Character-LCD write engine for the Spartan-3E starter board, downstream of MiniAlu. MiniAlu presents a byte plus a register-select flag on a valid/ready handshake. This block serialises the byte into the LCD's 4-bit bus protocol: high nibble, enable pulse, gap, low nibble, enable pulse, then a command-settle wait. All timing comes from cycle counters, so the bench can shrink the delays through parameters.

Parameters:
SETUP_CYC, 2, cycles that RS/D are stable before oLCD_E rises (>=1)
E_PULSE_CYC, 12, oLCD_E high time per nibble (240 ns at 50 MHz) (>=1)
NIBBLE_GAP_CYC, 50, E-low gap between high and low nibble (1 us) (>=1)
CMD_GAP_CYC, 2000, settle wait after last nibble for normal writes (40 us) (>=1)
CLEAR_GAP_CYC, 82000, settle wait after Clear/Home commands (1.64 ms) (>=1)

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high
iData  in  8  byte to write
iRS  in  1  0 = instruction, 1 = data register
iNibbleOnly  in  1  1 = send only iData[7:4] (init-sequence writes)
iValid  in  1  request qualifier
oReady  out  1  block idle, can accept
oDone  out  1  one-cycle pulse, transaction complete
oLCD_E  out  1  LCD enable
oLCD_RS  out  1  LCD register select
oLCD_RW  out  1  LCD read/write, tied to 0
oLCD_D  out  4  LCD data nibble (SF_D[11:8])

Behaviour:
- Reset (sampled at a rising edge): state IDLE, oReady=1, oDone=0, oLCD_E=0, oLCD_RS=0, oLCD_RW=0, oLCD_D=0, all counters cleared. Reset mid-transaction aborts it; oLCD_E is 0 from the next edge and no oDone is issued.
- Accept: a transfer is accepted on an edge where iValid=1 and oReady=1. iData, iRS and iNibbleOnly are registered at that edge and held for the whole transaction. oReady goes to 0 from the next cycle. iValid while oReady=0 is ignored; nothing is queued.
- States and dwell in cycles, each counted from its first cycle:
  - IDLE: waits for accept.
  - HI_SETUP (SETUP_CYC): D=data[7:4], RS=reg, E=0.
  - HI_PULSE (E_PULSE_CYC): E=1, D and RS unchanged.
  - HI_GAP (NIBBLE_GAP_CYC): E=0.
  - LO_SETUP (SETUP_CYC): D=data[3:0], E=0.
  - LO_PULSE (E_PULSE_CYC): E=1.
  - WAIT (CMD_GAP_CYC or CLEAR_GAP_CYC): E=0, D and RS held.
- Transition order: IDLE -> HI_SETUP -> HI_PULSE -> HI_GAP -> LO_SETUP -> LO_PULSE -> WAIT -> IDLE.
- Nibble-only mode: HI_PULSE goes directly to WAIT, which always uses CMD_GAP_CYC.
- Wait selection: WAIT uses CLEAR_GAP_CYC when RS=0 and data is 0x01, 0x02 or 0x03. Otherwise it uses CMD_GAP_CYC.
- Completion: on the cycle after the last WAIT cycle, the state is IDLE, oReady=1, oDone=1 (single cycle), oLCD_D=0, oLCD_RS=0.
- Back-to-back: iValid held high during that cycle is accepted on it, so idle time between transactions is exactly 1 cycle.
- Busy-cycle count (oReady=0): 2*SETUP_CYC + 2*E_PULSE_CYC + NIBBLE_GAP_CYC + wait for a full byte; SETUP_CYC + E_PULSE_CYC + CMD_GAP_CYC for nibble-only.
- Outputs: oLCD_E is glitch-free, driven from a register.
- Counters: wide enough for CLEAR_GAP_CYC (17 bits at default). A counter reaching its terminal value advances the state; there is no wrap-around within a state.

Test Plan:
(Bench parameters: SETUP=2, E_PULSE=3, NIBBLE_GAP=4, CMD_GAP=5, CLEAR_GAP=9.)
- Reset: hold Reset 2 cycles -> oReady=1, oDone=0, oLCD_E=0, oLCD_D=0, oLCD_RW=0 throughout.
- Data write: iData=0x48, iRS=1, 1-cycle iValid -> oReady low 19 cycles. oLCD_D=0x4 with E high for cycles 3-5, then oLCD_D=0x8 with E high for cycles 12-14. oLCD_RS=1 in cycles 1-19. oDone pulses in cycle 20.
- Clear command: iData=0x01, iRS=0 -> busy 23 cycles (WAIT=9); oLCD_RS=0 throughout.
- Nibble-only: iData=0x30, iNibbleOnly=1 -> exactly one E pulse of 3 cycles with D=0x3; busy 10 cycles; oDone in cycle 11.
- Back-to-back with ignored request: iValid held high with 0x41 then 0x42 -> second accepted on the oDone cycle. A third iValid pulse mid-transfer is ignored; exactly two transactions occur.
- Mid-operation reset: Reset asserted during HI_PULSE -> oLCD_E=0 the next cycle, no oDone, oReady=1; a fresh write afterwards completes normally.
